ifetch_unit: RTL and testbench

- Instruction fetch front end.
- Acts as Wishbone master that issues word reads to the ROMBlock instruction memory slave.
- Buffers returned words with their PCs in a small prefetch FIFO.
- Presents them to the decode stage over a valid/ready handshake; a redirect (flush) input restarts fetch at a new PC.

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/wishbone_if.sv | 26 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/ifetch_unit.sv | 126 ++++++++++++
 tb/tb_ifetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, Wishbone
// transfer-width codes and the prefetch FIFO entry layout.
package ifetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    FETCH,
    STALL,
    FLUSH
  } fetch_state_t;

  typedef enum logic [1:0] {
    WB_WIDTH_BYTE = 2'b00,
    WB_WIDTH_HALF = 2'b01,
    WB_WIDTH_WORD = 2'b10
  } wb_width_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/wishbone_if.sv
// Minimal Wishbone bundle used between the fetch unit and the ROMBlock slave.
interface WISHBONE_IF #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [1:0]    width;
  logic [DW-1:0] data_write;
  logic          ack;
  logic [DW-1:0] data_read;

  modport master (
    output cyc, stb, we, addr, width, data_write,
    input  ack, data_read
  );

  modport slave (
    input  cyc, stb, we, addr, width, data_write,
    output ack, data_read
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. The head entry is held in its own
// register so it stays put when the FIFO drains, and a word pushed into an
// empty FIFO appears at the head on the following cycle.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [CW-1:0] count_n;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next read pointer and occupancy after this cycle's push/pop
  always_comb begin
    rd_ptr_n = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO at once
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Head register: forward the incoming word when it becomes the head,
  // otherwise load the slot the read pointer lands on; hold when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else if (!clear && (count_n != '0)) begin
      head <= (push_ok && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: Wishbone master reading words from the
// ROMBlock, a prefetch FIFO, and a valid/ready port towards decode.
// Optional macro IFETCH_BYPASS_EN: when the FIFO is empty and decode is
// ready, an acked word is handed straight to decode in the same cycle.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter int               FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  WISHBONE_IF.master      mem_wb,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  logic            cyc_q;
  logic [XLEN-1:0] fetch_pc;

  logic            ack_v;
  logic            bypass;
  logic            push_en;
  logic            pop_en;
  logic            fifo_empty;
  logic            unused_fifo_full;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   occ_next;
  logic [1:0]      unused_flush_lsbs;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // An ack only counts while our own bus cycle is open
  assign ack_v = cyc_q && mem_wb.ack && !rst;

`ifdef IFETCH_BYPASS_EN
  assign bypass = ack_v && fifo_empty && if_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Flush discards the word acked in the same cycle and any pending pop
  assign push_en  = ack_v && !flush && !bypass;
  assign pop_en   = !fifo_empty && if_ready && !flush;
  assign occ_next = fifo_count + CW'(push_en) - CW'(pop_en);

  assign push_entry = '{pc: fetch_pc, instr: mem_wb.data_read};
  assign unused_flush_lsbs = flush_pc[1:0];

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push_en),
    .din   (push_entry),
    .pop   (pop_en),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  assign if_valid = !fifo_empty || bypass;
  assign if_instr = bypass ? mem_wb.data_read : head.instr;
  assign if_pc    = bypass ? fetch_pc : head.pc;

  assign mem_wb.cyc        = cyc_q;
  assign mem_wb.stb        = cyc_q;
  assign mem_wb.we         = 1'b0;
  assign mem_wb.width      = WB_WIDTH_WORD;
  assign mem_wb.addr       = fetch_pc;
  assign mem_wb.data_write = '0;

  // Fetch FSM: holds a request until ack, issues back-to-back while FIFO
  // space remains after this cycle's push/pop, parks in STALL when full
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      cyc_q    <= 1'b0;
      fetch_pc <= RESET_VECTOR;
    end else if (flush) begin
      state    <= FLUSH;
      cyc_q    <= 1'b0;
      fetch_pc <= {flush_pc[XLEN-1:2], 2'b00};
    end else begin
      case (state)
        FETCH: begin
          if (ack_v) fetch_pc <= fetch_pc + XLEN'(4);
          if (cyc_q && !ack_v) begin
            cyc_q <= 1'b1;
          end else if (occ_next == CW'(FIFO_DEPTH)) begin
            state <= STALL;
            cyc_q <= 1'b0;
          end else begin
            cyc_q <= 1'b1;
          end
        end
        STALL: begin
          if (pop_en) begin
            state <= FETCH;
            cyc_q <= 1'b1;
          end
        end
        FLUSH: begin
          state <= FETCH;
          cyc_q <= 1'b1;
        end
        default: begin
          state <= FETCH;
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a small ROM slave model.
module tb_ifetch_unit;
  import ifetch_pkg::*;

`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int vectors     = 0;
  int miscompares = 0;
  bit slave_en;
  bit stray_ack;
  int slave_wait;
  int wait_cnt;
  int ack_count;

  WISHBONE_IF wb ();

  ifetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_wb   (wb),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .flush    (flush),
    .flush_pc (flush_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return 32'hB000_0000 ^ a;
  endfunction

  task automatic slave_drive();
    if (wb.cyc === 1'b1 && slave_en) begin
      if (wait_cnt == slave_wait) begin
        wb.ack       = 1'b1;
        wb.data_read = rom(wb.addr);
        wait_cnt     = 0;
        ack_count++;
      end else begin
        wb.ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      wb.ack       = stray_ack;
      wb.data_read = 32'hDEAD_BEEF;
      wait_cnt     = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    slave_drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_ready = 1'b0; flush = 1'b0; flush_pc = '0;
    slave_en = 1'b0; stray_ack = 1'b0; slave_wait = 0; ack_count = 0;
    step();
    step();
    rst = 1'b0;
    slave_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", if_valid); end
    vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got %h want 0", if_instr); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", if_pc); end
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL rst_cyc got %0b want 0", wb.cyc); end
    vectors++; if (wb.stb !== 1'b0) begin miscompares++; $display("FAIL rst_stb got %0b want 0", wb.stb); end
    vectors++; if (wb.we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %0b want 0", wb.we); end
    vectors++; if (wb.width !== 2'b10) begin miscompares++; $display("FAIL rst_width got %b want 10", wb.width); end
    vectors++; if (wb.addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", wb.addr); end
    vectors++; if (wb.data_write !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", wb.data_write); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    if_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++; if (wb.cyc !== 1'b1) begin miscompares++; $display("FAIL stream_cyc c%0d got %0b want 1", k, wb.cyc); end
      vectors++; if (wb.addr !== 32'(4 * (k - 1))) begin miscompares++; $display("FAIL stream_addr c%0d got %h want %h", k, wb.addr, 4 * (k - 1)); end
      vectors++; if (if_valid !== ((k - 1) >= LAT)) begin miscompares++; $display("FAIL stream_valid c%0d got %0b want %0b", k, if_valid, (k - 1) >= LAT); end
      if ((k - 1) >= LAT) begin
        exp_pc = 32'(4 * (k - 1 - LAT));
        vectors++; if (if_pc !== exp_pc) begin miscompares++; $display("FAIL stream_pc c%0d got %h want %h", k, if_pc, exp_pc); end
        vectors++; if (if_instr !== rom(exp_pc)) begin miscompares++; $display("FAIL stream_instr c%0d got %h want %h", k, if_instr, rom(exp_pc)); end
      end
    end
    if_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      stray_ack = (k == 6 || k == 7);
      step();
    end
    stray_ack = 1'b0;
    vectors++; if (ack_count !== 4) begin miscompares++; $display("FAIL bp_acks got %0d want 4", ack_count); end
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL bp_stall_cyc got %0b want 0", wb.cyc); end
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got %0b want 1", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL bp_pc_hold got %h want 0", if_pc); end
    vectors++; if (if_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL bp_instr_hold got %h want 00000013", if_instr); end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    vectors++; if (wb.cyc !== 1'b1) begin miscompares++; $display("FAIL bp_resume_cyc got %0b want 1", wb.cyc); end
    vectors++; if (wb.addr !== 32'h10) begin miscompares++; $display("FAIL bp_resume_addr got %h want 00000010", wb.addr); end
    vectors++; if (if_pc !== 32'h4) begin miscompares++; $display("FAIL bp_pop_pc got %h want 00000004", if_pc); end
    step();
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL bp_restall_cyc got %0b want 0", wb.cyc); end
    vectors++; if (ack_count !== 5) begin miscompares++; $display("FAIL bp_acks2 got %0d want 5", ack_count); end
  endtask

  task automatic test_wait_states();
    do_reset();
    slave_wait = 2;
    for (int k = 1; k <= 9; k++) begin
      step();
      vectors++; if (wb.stb !== 1'b1) begin miscompares++; $display("FAIL ws_stb c%0d got %0b want 1", k, wb.stb); end
      vectors++; if (wb.addr !== 32'(4 * ((k - 1) / 3))) begin miscompares++; $display("FAIL ws_addr c%0d got %h want %h", k, wb.addr, 4 * ((k - 1) / 3)); end
    end
    vectors++; if (ack_count !== 3) begin miscompares++; $display("FAIL ws_acks got %0d want 3", ack_count); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL ws_head_pc got %h want 0", if_pc); end
    slave_en = 1'b0;
    if_ready = 1'b1;
    step();
    vectors++; if (if_pc !== 32'h4) begin miscompares++; $display("FAIL ws_drain_pc1 got %h want 00000004", if_pc); end
    step();
    vectors++; if (if_pc !== 32'h8) begin miscompares++; $display("FAIL ws_drain_pc2 got %h want 00000008", if_pc); end
    vectors++; if (if_instr !== rom(32'h8)) begin miscompares++; $display("FAIL ws_drain_instr got %h want %h", if_instr, rom(32'h8)); end
    step();
    if_ready = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL ws_empty_valid got %0b want 0", if_valid); end
    vectors++; if (if_pc !== 32'h8) begin miscompares++; $display("FAIL ws_empty_pc_hold got %h want 00000008", if_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 1; k <= 4; k++) step();
    vectors++; if (wb.addr !== 32'hC) begin miscompares++; $display("FAIL fl_pre_addr got %h want 0000000c", wb.addr); end
    flush = 1'b1;
    flush_pc = 32'h0000_0102;
    if_ready = 1'b1;
    step();
    flush = 1'b0;
    if_ready = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL fl_valid got %0b want 0", if_valid); end
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL fl_idle_cyc got %0b want 0", wb.cyc); end
    step();
    vectors++; if (wb.cyc !== 1'b1) begin miscompares++; $display("FAIL fl_restart_cyc got %0b want 1", wb.cyc); end
    vectors++; if (wb.addr !== 32'h100) begin miscompares++; $display("FAIL fl_restart_addr got %h want 00000100", wb.addr); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL fl_still_empty got %0b want 0", if_valid); end
    step();
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL fl_new_valid got %0b want 1", if_valid); end
    vectors++; if (if_pc !== 32'h100) begin miscompares++; $display("FAIL fl_new_pc got %h want 00000100", if_pc); end
    vectors++; if (if_instr !== 32'hB000_0100) begin miscompares++; $display("FAIL fl_new_instr got %h want b0000100", if_instr); end
  endtask

  task automatic test_wrap();
    do_reset();
    slave_en = 1'b0;
    flush = 1'b1;
    flush_pc = 32'hFFFF_FFFF;
    step();
    flush = 1'b0;
    slave_en = 1'b1;
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL wr_idle_cyc got %0b want 0", wb.cyc); end
    step();
    vectors++; if (wb.addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_addr0 got %h want fffffffc", wb.addr); end
    step();
    vectors++; if (wb.addr !== 32'h0) begin miscompares++; $display("FAIL wr_addr1 got %h want 00000000", wb.addr); end
    vectors++; if (if_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_pc0 got %h want fffffffc", if_pc); end
    vectors++; if (if_instr !== 32'h4FFF_FFFC) begin miscompares++; $display("FAIL wr_instr0 got %h want 4ffffffc", if_instr); end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL wr_pc1 got %h want 00000000", if_pc); end
    vectors++; if (if_instr !== 32'h0000_0013) begin miscompares++; $display("FAIL wr_instr1 got %h want 00000013", if_instr); end
  endtask

  task automatic test_reset_midreq();
    do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL mr_valid got %0b want 0", if_valid); end
    vectors++; if (wb.cyc !== 1'b0) begin miscompares++; $display("FAIL mr_cyc got %0b want 0", wb.cyc); end
    vectors++; if (wb.addr !== 32'h0) begin miscompares++; $display("FAIL mr_addr got %h want 0", wb.addr); end
    step();
    vectors++; if (wb.addr !== 32'h0) begin miscompares++; $display("FAIL mr_refetch_addr got %h want 0", wb.addr); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL mr_no_stale got %0b want 0", if_valid); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pc;
    do_reset();
    step();
    if_ready = 1'b1;
    #1;
    vectors++; if (if_valid !== (LAT == 0)) begin miscompares++; $display("FAIL by_valid0 got %0b want %0b", if_valid, LAT == 0); end
    step();
    exp_pc = (LAT == 0) ? 32'h4 : 32'h0;
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL by_valid1 got %0b want 1", if_valid); end
    vectors++; if (if_pc !== exp_pc) begin miscompares++; $display("FAIL by_pc1 got %h want %h", if_pc, exp_pc); end
    vectors++; if (if_instr !== rom(exp_pc)) begin miscompares++; $display("FAIL by_instr1 got %h want %h", if_instr, rom(exp_pc)); end
    if_ready = 1'b0;
  endtask

  initial begin
    wb.ack = 1'b0;
    wb.data_read = '0;
    wait_cnt = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_flush();
    test_wrap();
    test_reset_midreq();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1);
  end

endmodule
